// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception type and ExcCode encodings,
// raw MEM-stage flag positions and Status/Cause field indices.
package cp0_exc_unit_pkg;

    // CP0 register numbers
    localparam logic [4:0] RegCount   = 5'd9;
    localparam logic [4:0] RegCompare = 5'd11;
    localparam logic [4:0] RegStatus  = 5'd12;
    localparam logic [4:0] RegCause   = 5'd13;
    localparam logic [4:0] RegEpc     = 5'd14;
    localparam logic [4:0] RegPrid    = 5'd15;
    localparam logic [4:0] RegConfig  = 5'd16;

    // Encoded exception types handed to the pipeline controller
    localparam logic [31:0] ExcTypeNone    = 32'h0;
    localparam logic [31:0] ExcTypeInt     = 32'h1;
    localparam logic [31:0] ExcTypeSyscall = 32'h8;
    localparam logic [31:0] ExcTypeRi      = 32'ha;
    localparam logic [31:0] ExcTypeOv      = 32'hc;
    localparam logic [31:0] ExcTypeTrap    = 32'hd;
    localparam logic [31:0] ExcTypeEret    = 32'he;

    // Cause.ExcCode values
    localparam logic [4:0] ExcCodeInt     = 5'h00;
    localparam logic [4:0] ExcCodeSyscall = 5'h08;
    localparam logic [4:0] ExcCodeRi      = 5'h0a;
    localparam logic [4:0] ExcCodeOv      = 5'h0c;
    localparam logic [4:0] ExcCodeTrap    = 5'h0d;

    // Raw excflags bit positions
    localparam int unsigned FlagSyscall = 8;
    localparam int unsigned FlagRi      = 9;
    localparam int unsigned FlagTrap    = 10;
    localparam int unsigned FlagOv      = 11;
    localparam int unsigned FlagEret    = 12;

    // Status / Cause field indices
    localparam int unsigned StatusIe    = 0;
    localparam int unsigned StatusExl   = 1;
    localparam int unsigned StatusImLo  = 8;
    localparam int unsigned StatusImHi  = 15;
    localparam int unsigned CauseExcLo  = 2;
    localparam int unsigned CauseExcHi  = 6;
    localparam int unsigned CauseIpLo   = 8;
    localparam int unsigned CauseIpSwHi = 9;
    localparam int unsigned CauseIpHwLo = 10;
    localparam int unsigned CauseIpHi   = 15;
    localparam int unsigned CauseBd     = 31;

    localparam logic [31:0] StatusRst = 32'h1000_0000;

    // Map an encoded exception type to the ExcCode recorded in Cause
    function automatic logic [4:0] exc_code(input logic [31:0] exc_type);
        logic [4:0] code;
        case (exc_type)
            ExcTypeSyscall: code = ExcCodeSyscall;
            ExcTypeRi:      code = ExcCodeRi;
            ExcTypeTrap:    code = ExcCodeTrap;
            ExcTypeOv:      code = ExcCodeOv;
            default:        code = ExcCodeInt;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer. Count free-runs, Compare match raises a sticky
// interrupt that only a Compare write (or reset) clears.
module cp0_timer
    import cp0_exc_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_int_q, timer_int_d;

    // Next-state: increment, match detect, MTC0 loads (Compare write beats a match)
    always_comb begin
        count_d     = count_q + 32'd1;
        compare_d   = compare_q;
        timer_int_d = timer_int_q;
        if ((count_q == compare_q) && (compare_q != 32'd0)) begin
            timer_int_d = 1'b1;
        end
        if (we_i && (waddr_i == RegCount)) begin
            count_d = wdata_i;
        end
        if (we_i && (waddr_i == RegCompare)) begin
            compare_d   = wdata_i;
            timer_int_d = 1'b0;
        end
    end

    // Timer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            compare_q   <= '0;
            timer_int_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            compare_q   <= compare_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 register file with MEM-stage exception detection, prioritisation and commit.
// Optional Count/Compare timer is built only when CP0_TIMER_EN is defined.
module cp0_exc_unit
    import cp0_exc_unit_pkg::*;
#(
    parameter logic [31:0] PRID   = 32'h004c_0102,
    parameter logic [31:0] CONFIG = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  int_i,
    input  logic [31:0] excflags_i,
    input  logic [31:0] inst_addr_i,
    input  logic        in_delayslot_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] epc_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] status_fwd, cause_fwd, epc_fwd;
    logic [31:0] exc_type;
    logic        int_pending;

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .count_o     (count_o),
        .compare_o   (compare_o),
        .timer_int_o (timer_int_o)
    );
`else
    assign count_o     = '0;
    assign compare_o   = '0;
    assign timer_int_o = 1'b0;
`endif

    // MEM-side view with the same-cycle WB MTC0 forwarded in
    always_comb begin
        status_fwd = status_q;
        cause_fwd  = cause_q;
        epc_fwd    = epc_q;
        if (we_i && (waddr_i == RegStatus)) begin
            status_fwd = wdata_i;
        end
        if (we_i && (waddr_i == RegCause)) begin
            cause_fwd[CauseIpSwHi:CauseIpLo] = wdata_i[CauseIpSwHi:CauseIpLo];
        end
        if (we_i && (waddr_i == RegEpc)) begin
            epc_fwd = wdata_i;
        end
    end

    assign int_pending = |(cause_fwd[CauseIpHi:CauseIpLo] & status_fwd[StatusImHi:StatusImLo]);

    // Exception detect in priority order; bubbles and reset never raise one
    always_comb begin
        exc_type = ExcTypeNone;
        if (!rst && (inst_addr_i != 32'd0)) begin
            if (int_pending && status_fwd[StatusIe] && !status_fwd[StatusExl]) begin
                exc_type = ExcTypeInt;
            end else if (excflags_i[FlagSyscall]) begin
                exc_type = ExcTypeSyscall;
            end else if (excflags_i[FlagRi]) begin
                exc_type = ExcTypeRi;
            end else if (excflags_i[FlagTrap]) begin
                exc_type = ExcTypeTrap;
            end else if (excflags_i[FlagOv]) begin
                exc_type = ExcTypeOv;
            end else if (excflags_i[FlagEret]) begin
                exc_type = ExcTypeEret;
            end
        end
    end

    // Next-state: MTC0 applied first, then the commit overrides the fields it owns
    always_comb begin
        status_d = status_fwd;
        cause_d  = cause_fwd;
        epc_d    = epc_fwd;
        cause_d[CauseIpHi:CauseIpHwLo] = int_i;
        if (exc_type == ExcTypeEret) begin
            status_d[StatusExl] = 1'b0;
        end else if (exc_type != ExcTypeNone) begin
            // A nested exception under EXL keeps the original return point
            if (!status_fwd[StatusExl]) begin
                epc_d            = in_delayslot_i ? (inst_addr_i - 32'd4) : inst_addr_i;
                cause_d[CauseBd] = in_delayslot_i;
            end
            status_d[StatusExl]             = 1'b1;
            cause_d[CauseExcHi:CauseExcLo] = exc_code(exc_type);
        end
    end

    // CP0 register state
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= StatusRst;
            cause_q  <= '0;
            epc_q    <= '0;
        end else begin
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
        end
    end

    // MFC0 read mux over stored registers
    always_comb begin
        rdata_o = '0;
        if (!rst) begin
            case (raddr_i)
                RegCount:   rdata_o = count_o;
                RegCompare: rdata_o = compare_o;
                RegStatus:  rdata_o = status_q;
                RegCause:   rdata_o = cause_q;
                RegEpc:     rdata_o = epc_q;
                RegPrid:    rdata_o = PRID;
                RegConfig:  rdata_o = CONFIG;
                default:    rdata_o = '0;
            endcase
        end
    end

    assign excepttype_o = exc_type;
    assign epc_o        = epc_fwd;
    assign status_o     = status_q;
    assign cause_o      = cause_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit; timer checks follow CP0_TIMER_EN.
module tb_cp0_exc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  int_i;
    logic [31:0] excflags_i;
    logic [31:0] inst_addr_i;
    logic        in_delayslot_i;
    logic [31:0] excepttype_o;
    logic [31:0] epc_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic        timer_int_o;

    int errors = 0;
    int checks = 0;

    cp0_exc_unit dut (
        .clk            (clk),
        .rst            (rst),
        .we_i           (we_i),
        .waddr_i        (waddr_i),
        .wdata_i        (wdata_i),
        .raddr_i        (raddr_i),
        .rdata_o        (rdata_o),
        .int_i          (int_i),
        .excflags_i     (excflags_i),
        .inst_addr_i    (inst_addr_i),
        .in_delayslot_i (in_delayslot_i),
        .excepttype_o   (excepttype_o),
        .epc_o          (epc_o),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .count_o        (count_o),
        .compare_o      (compare_o),
        .timer_int_o    (timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_i           = 1'b0;
        waddr_i        = 5'd0;
        wdata_i        = 32'd0;
        excflags_i     = 32'd0;
        inst_addr_i    = 32'd0;
        in_delayslot_i = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        int_i   = 6'd0;
        raddr_i = 5'd12;
        idle();
        tick();
        tick();
        inst_addr_i = 32'h100;
        excflags_i  = 32'h100;
        #1;
        checks++;
        if (excepttype_o !== 32'h0) begin
            errors++; $display("FAIL reset_exctype: got %h want %h", excepttype_o, 32'h0);
        end
        checks++;
        if (rdata_o !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h want %h", rdata_o, 32'h0);
        end
        idle();
        rst = 1'b0;
        #1;
        checks++;
        if (status_o !== 32'h1000_0000) begin
            errors++; $display("FAIL reset_status: got %h want %h", status_o, 32'h1000_0000);
        end
        checks++;
        if (cause_o !== 32'h0 || epc_o !== 32'h0 || timer_int_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: got cause %h epc %h tint %b want 0 0 0",
                     cause_o, epc_o, timer_int_o);
        end
        checks++;
        if (rdata_o !== 32'h1000_0000) begin
            errors++; $display("FAIL reset_mfc0_status: got %h want %h", rdata_o, 32'h1000_0000);
        end
        raddr_i = 5'd15;
        #1;
        checks++;
        if (rdata_o !== 32'h004c_0102) begin
            errors++; $display("FAIL mfc0_prid: got %h want %h", rdata_o, 32'h004c_0102);
        end
        raddr_i = 5'd16;
        #1;
        checks++;
        if (rdata_o !== 32'h0000_8000) begin
            errors++; $display("FAIL mfc0_config: got %h want %h", rdata_o, 32'h0000_8000);
        end
        checks++;
        if (count_o !== 32'd0) begin
            errors++; $display("FAIL count_start: got %h want %h", count_o, 32'd0);
        end
`ifdef CP0_TIMER_EN
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if (count_o !== 32'(i)) begin
                errors++; $display("FAIL count_run: got %h want %h", count_o, 32'(i));
            end
        end
`else
        tick();
        checks++;
        if (count_o !== 32'd0) begin
            errors++; $display("FAIL count_absent: got %h want %h", count_o, 32'd0);
        end
`endif
    endtask

    task automatic test_syscall();
        inst_addr_i = 32'h100;
        excflags_i  = 32'h100;
        #1;
        checks++;
        if (excepttype_o !== 32'h8) begin
            errors++; $display("FAIL syscall_type: got %h want %h", excepttype_o, 32'h8);
        end
        tick();
        idle();
        checks++;
        if (epc_o !== 32'h100) begin
            errors++; $display("FAIL syscall_epc: got %h want %h", epc_o, 32'h100);
        end
        checks++;
        if (cause_o !== 32'h20) begin
            errors++; $display("FAIL syscall_cause: got %h want %h", cause_o, 32'h20);
        end
        checks++;
        if (status_o !== 32'h1000_0002) begin
            errors++; $display("FAIL syscall_status: got %h want %h", status_o, 32'h1000_0002);
        end
    endtask

    // Overflow while EXL=1 keeps EPC/BD, then again with EXL cleared by a same-edge MTC0
    task automatic test_overflow();
        inst_addr_i    = 32'h204;
        excflags_i     = 32'h800;
        in_delayslot_i = 1'b1;
        #1;
        checks++;
        if (excepttype_o !== 32'hc) begin
            errors++; $display("FAIL ov_nested_type: got %h want %h", excepttype_o, 32'hc);
        end
        tick();
        idle();
        checks++;
        if (epc_o !== 32'h100 || cause_o !== 32'h30) begin
            errors++;
            $display("FAIL ov_nested_hold: got epc %h cause %h want 100 30", epc_o, cause_o);
        end
        we_i           = 1'b1;
        waddr_i        = 5'd12;
        wdata_i        = 32'h1000_0000;
        inst_addr_i    = 32'h204;
        excflags_i     = 32'h800;
        in_delayslot_i = 1'b1;
        #1;
        checks++;
        if (excepttype_o !== 32'hc) begin
            errors++; $display("FAIL ov_ds_type: got %h want %h", excepttype_o, 32'hc);
        end
        tick();
        idle();
        checks++;
        if (epc_o !== 32'h200) begin
            errors++; $display("FAIL ov_ds_epc: got %h want %h", epc_o, 32'h200);
        end
        checks++;
        if (cause_o !== 32'h8000_0030) begin
            errors++; $display("FAIL ov_ds_cause: got %h want %h", cause_o, 32'h8000_0030);
        end
        checks++;
        if (status_o !== 32'h1000_0002) begin
            errors++; $display("FAIL ov_ds_status: got %h want %h", status_o, 32'h1000_0002);
        end
    endtask

    // Stays within one clock period so nothing commits
    task automatic test_priority();
        logic [31:0] flags_tab [7];
        logic [31:0] exp_tab   [7];
        flags_tab = '{32'h1f00, 32'h1e00, 32'h1c00, 32'h1800, 32'h1000, 32'h0, 32'h1};
        exp_tab   = '{32'h8, 32'ha, 32'hd, 32'hc, 32'he, 32'h0, 32'h0};
        inst_addr_i = 32'h40;
        for (int i = 0; i < 7; i++) begin
            excflags_i = flags_tab[i];
            #1;
            checks++;
            if (excepttype_o !== exp_tab[i]) begin
                errors++;
                $display("FAIL priority[%0d]: got %h want %h", i, excepttype_o, exp_tab[i]);
            end
        end
        inst_addr_i = 32'h0;
        excflags_i  = 32'h1f00;
        #1;
        checks++;
        if (excepttype_o !== 32'h0) begin
            errors++; $display("FAIL bubble: got %h want %h", excepttype_o, 32'h0);
        end
        idle();
    endtask

    task automatic test_interrupt();
        tick();
        int_i   = 6'b000001;
        we_i    = 1'b1;
        waddr_i = 5'd12;
        wdata_i = 32'h0000_0401;
        tick();
        idle();
        raddr_i = 5'd13;
        #1;
        checks++;
        if (status_o !== 32'h401 || rdata_o !== 32'h8000_0430) begin
            errors++;
            $display("FAIL int_setup: got status %h cause %h want 401 80000430",
                     status_o, rdata_o);
        end
        inst_addr_i = 32'h400;
        #1;
        checks++;
        if (excepttype_o !== 32'h1) begin
            errors++; $display("FAIL int_type: got %h want %h", excepttype_o, 32'h1);
        end
        we_i    = 1'b1;
        waddr_i = 5'd12;
        wdata_i = 32'h403;
        #1;
        checks++;
        if (excepttype_o !== 32'h0) begin
            errors++; $display("FAIL int_exl_masked: got %h want %h", excepttype_o, 32'h0);
        end
        wdata_i = 32'h400;
        #1;
        checks++;
        if (excepttype_o !== 32'h0) begin
            errors++; $display("FAIL int_ie_masked: got %h want %h", excepttype_o, 32'h0);
        end
        wdata_i = 32'h001;
        #1;
        checks++;
        if (excepttype_o !== 32'h0) begin
            errors++; $display("FAIL int_im_masked: got %h want %h", excepttype_o, 32'h0);
        end
        we_i       = 1'b0;
        excflags_i = 32'h100;
        #1;
        checks++;
        if (excepttype_o !== 32'h1) begin
            errors++; $display("FAIL int_over_syscall: got %h want %h", excepttype_o, 32'h1);
        end
        tick();
        idle();
        checks++;
        if (epc_o !== 32'h400 || cause_o !== 32'h400 || status_o !== 32'h403) begin
            errors++;
            $display("FAIL int_commit: got epc %h cause %h status %h want 400 400 403",
                     epc_o, cause_o, status_o);
        end
    endtask

    task automatic test_cause_write();
        we_i    = 1'b1;
        waddr_i = 5'd13;
        wdata_i = 32'hffff_ffff;
        tick();
        idle();
        checks++;
        if (cause_o !== 32'h700) begin
            errors++; $display("FAIL cause_ip_write: got %h want %h", cause_o, 32'h700);
        end
        int_i = 6'd0;
        tick();
        checks++;
        if (cause_o !== 32'h300 || status_o !== 32'h403 || epc_o !== 32'h400) begin
            errors++;
            $display("FAIL cause_int_sample: got cause %h status %h epc %h want 300 403 400",
                     cause_o, status_o, epc_o);
        end
    endtask

    task automatic test_eret_fwd();
        we_i        = 1'b1;
        waddr_i     = 5'd14;
        wdata_i     = 32'h300;
        inst_addr_i = 32'h500;
        excflags_i  = 32'h1000;
        #1;
        checks++;
        if (epc_o !== 32'h300) begin
            errors++; $display("FAIL eret_epc_fwd: got %h want %h", epc_o, 32'h300);
        end
        checks++;
        if (excepttype_o !== 32'he) begin
            errors++; $display("FAIL eret_type: got %h want %h", excepttype_o, 32'he);
        end
        tick();
        idle();
        checks++;
        if (status_o !== 32'h401 || epc_o !== 32'h300 || cause_o !== 32'h300) begin
            errors++;
            $display("FAIL eret_commit: got status %h epc %h cause %h want 401 300 300",
                     status_o, epc_o, cause_o);
        end
    endtask

    task automatic test_unmapped();
        we_i    = 1'b1;
        waddr_i = 5'd3;
        wdata_i = 32'hdead_beef;
        tick();
        idle();
        raddr_i = 5'd3;
        #1;
        checks++;
        if (rdata_o !== 32'h0) begin
            errors++; $display("FAIL unmapped_read: got %h want %h", rdata_o, 32'h0);
        end
        raddr_i = 5'd14;
        #1;
        checks++;
        if (rdata_o !== 32'h300) begin
            errors++; $display("FAIL mfc0_epc: got %h want %h", rdata_o, 32'h300);
        end
    endtask

    task automatic test_timer();
`ifdef CP0_TIMER_EN
        we_i    = 1'b1;
        waddr_i = 5'd11;
        wdata_i = 32'd5;
        tick();
        waddr_i = 5'd9;
        wdata_i = 32'd0;
        tick();
        idle();
        checks++;
        if (count_o !== 32'd0 || compare_o !== 32'd5 || timer_int_o !== 1'b0) begin
            errors++;
            $display("FAIL timer_setup: got count %h cmp %h tint %b want 0 5 0",
                     count_o, compare_o, timer_int_o);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (count_o !== 32'(i) || timer_int_o !== 1'b0) begin
                errors++;
                $display("FAIL timer_pre[%0d]: got count %h tint %b want %h 0",
                         i, count_o, timer_int_o, 32'(i));
            end
        end
        tick();
        checks++;
        if (timer_int_o !== 1'b1) begin
            errors++; $display("FAIL timer_rise: got %b want 1", timer_int_o);
        end
        tick();
        checks++;
        if (timer_int_o !== 1'b1) begin
            errors++; $display("FAIL timer_sticky: got %b want 1", timer_int_o);
        end
        we_i    = 1'b1;
        waddr_i = 5'd11;
        wdata_i = 32'd100;
        tick();
        idle();
        raddr_i = 5'd11;
        #1;
        checks++;
        if (timer_int_o !== 1'b0 || rdata_o !== 32'd100) begin
            errors++;
            $display("FAIL timer_clear: got tint %b cmp %h want 0 64", timer_int_o, rdata_o);
        end
        we_i    = 1'b1;
        waddr_i = 5'd9;
        wdata_i = 32'hffff_ffff;
        tick();
        idle();
        tick();
        checks++;
        if (count_o !== 32'd0) begin
            errors++; $display("FAIL count_wrap: got %h want %h", count_o, 32'd0);
        end
`else
        we_i    = 1'b1;
        waddr_i = 5'd9;
        wdata_i = 32'h55;
        tick();
        waddr_i = 5'd11;
        wdata_i = 32'd5;
        tick();
        idle();
        raddr_i = 5'd9;
        #1;
        checks++;
        if (count_o !== 32'd0 || rdata_o !== 32'd0) begin
            errors++; $display("FAIL count_off: got %h/%h want 0/0", count_o, rdata_o);
        end
        raddr_i = 5'd11;
        #1;
        checks++;
        if (compare_o !== 32'd0 || rdata_o !== 32'd0 || timer_int_o !== 1'b0) begin
            errors++;
            $display("FAIL compare_off: got %h/%h tint %b want 0/0 0",
                     compare_o, rdata_o, timer_int_o);
        end
`endif
    endtask

    task automatic test_reset_mid();
        rst         = 1'b1;
        we_i        = 1'b1;
        waddr_i     = 5'd14;
        wdata_i     = 32'h77;
        inst_addr_i = 32'h600;
        excflags_i  = 32'h100;
        raddr_i     = 5'd12;
        #1;
        checks++;
        if (excepttype_o !== 32'h0 || rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_comb: got type %h rdata %h want 0 0", excepttype_o, rdata_o);
        end
        tick();
        rst = 1'b0;
        idle();
        #1;
        checks++;
        if (status_o !== 32'h1000_0000 || epc_o !== 32'h0 || cause_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_regs: got status %h epc %h cause %h want 10000000 0 0",
                     status_o, epc_o, cause_o);
        end
        checks++;
        if (count_o !== 32'h0 || compare_o !== 32'h0 || timer_int_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_timer: got count %h cmp %h tint %b want 0 0 0",
                     count_o, compare_o, timer_int_o);
        end
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_overflow();
        test_priority();
        test_interrupt();
        test_cause_write();
        test_eret_fwd();
        test_unmapped();
        test_timer();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
